luma4x4_mode_ctrl: RTL and testbench

LUMA4X4_MODE_CTRL -- requirements
Module: luma4x4_mode_ctrl

---
 rtl/luma4x4_mode_ctrl_pkg.sv | 32 +++
 rtl/luma4x4_mode_ctrl_sad4x4.sv | 26 ++
 rtl/luma4x4_mode_ctrl.sv | 163 ++++++++++++++++
 tb/tb_luma4x4_mode_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/luma4x4_mode_ctrl_pkg.sv
// Shared intra-prediction definitions for the luma 4x4 mode controller.
//   - state_t   : controller FSM states
//   - MODE_LUT  : residual mux select (mode_sel) -> H.264 Intra4x4 mode number
//   - NMODE     : residual modes scanned per block
//   - SAD_W / COST_W : SAD and macroblock-cost widths
package luma4x4_mode_ctrl_pkg;

    localparam int NMODE  = 8;
    localparam int SAD_W  = 12;   // 16 x 128 = 2048 needs 12 bits
    localparam int COST_W = 16;   // 16 x 2048 = 32768 fits in 16 bits

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENA,
        ST_WAIT,
        ST_SCAN,
        ST_DONE
    } state_t;

    // Index = mode_sel (V,H,VL,VR,HU,HD,DDL,DDR), value = H.264 mode number.
    localparam logic [7:0][3:0] MODE_LUT = {
        4'd4,   // 7 DDR
        4'd3,   // 6 DDL
        4'd6,   // 5 HD
        4'd8,   // 4 HU
        4'd5,   // 3 VR
        4'd7,   // 2 VL
        4'd1,   // 1 H
        4'd0    // 0 V
    };

endpackage

// File: rtl/luma4x4_mode_ctrl_sad4x4.sv
// sad4x4: combinational sum of absolute values of a 4x4 signed residual.
//   res : 16 x 8-bit signed samples, sample i at res[8*i +: 8]
//   sad : 12-bit unsigned sum, max 2048 (all samples -128)
module sad4x4 (
    input  logic [127:0] res,
    output logic [11:0]  sad
);

    logic [15:0][7:0] mag;
    logic [3:0][9:0]  row_sum;

    // Two's-complement negate in 8 bits maps -128 to 0x80, read unsigned as 128.
    for (genvar i = 0; i < 16; i++) begin : g_abs
        assign mag[i] = res[8*i+7] ? (~res[8*i +: 8] + 8'd1) : res[8*i +: 8];
    end

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_sum[r] = 10'(mag[4*r]) + 10'(mag[4*r+1]) +
                         10'(mag[4*r+2]) + 10'(mag[4*r+3]);
        end
        sad = 12'(row_sum[0]) + 12'(row_sum[1]) +
              12'(row_sum[2]) + 12'(row_sum[3]);
    end

endmodule

// File: rtl/luma4x4_mode_ctrl.sv
// luma4x4_mode_ctrl: walks NBLK 4x4 blocks, scans NMODE residual modes per
// block, keeps the minimum-SAD mode and accumulates the macroblock cost.
//   clk, reset(async, active low), start, abort : control inputs
//   res        : residual for the mode on mode_sel (held stable from WAIT)
//   res_enable : strobe to the residual datapath (ENA only)
//   mode_sel   : residual mux select, stepped during SCAN
//   blk_idx    : block in progress; busy : not IDLE
//   blk_valid / best_mode / best_sad : per-block result, valid in DONE
//   mb_cost    : running sum of best_sad; mb_done : last block's DONE
module luma4x4_mode_ctrl #(
    parameter int NBLK  = 16,
    parameter int NMODE = luma4x4_mode_ctrl_pkg::NMODE
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [127:0] res,
    output logic         res_enable,
    output logic [2:0]   mode_sel,
    output logic [3:0]   blk_idx,
    output logic         busy,
    output logic         blk_valid,
    output logic [3:0]   best_mode,
    output logic [11:0]  best_sad,
    output logic [15:0]  mb_cost,
    output logic         mb_done
);
    import luma4x4_mode_ctrl_pkg::*;

    localparam logic [2:0] LAST_MODE = 3'(NMODE - 1);
    localparam logic [3:0] LAST_BLK  = 4'(NBLK - 1);

    state_t             state_q, state_d;
    logic               res_enable_q, res_enable_d;
    logic [2:0]         mode_sel_q, mode_sel_d;
    logic [3:0]         blk_idx_q, blk_idx_d;
    logic               blk_valid_q, blk_valid_d;
    logic               mb_done_q, mb_done_d;
    logic [3:0]         best_mode_q, best_mode_d;
    logic [SAD_W-1:0]   best_sad_q, best_sad_d;
    logic [COST_W-1:0]  mb_cost_q, mb_cost_d;
    logic [SAD_W-1:0]   min_sad_q, min_sad_d;
    logic [2:0]         min_sel_q, min_sel_d;

    logic [SAD_W-1:0]   sad;
    logic               take_new;
    logic [SAD_W-1:0]   cand_sad;
    logic [2:0]         cand_sel;

    sad4x4 u_sad (
        .res (res),
        .sad (sad)
    );

    // First scanned mode always loads; later ones must be strictly smaller,
    // so ties keep the lower mode_sel.
    assign take_new = (mode_sel_q == 3'd0) || (sad < min_sad_q);
    assign cand_sad = take_new ? sad        : min_sad_q;
    assign cand_sel = take_new ? mode_sel_q : min_sel_q;

    always_comb begin
        state_d     = state_q;
        mode_sel_d  = 3'd0;
        blk_idx_d   = blk_idx_q;
        best_mode_d = best_mode_q;
        best_sad_d  = best_sad_q;
        mb_cost_d   = mb_cost_q;
        min_sad_d   = min_sad_q;
        min_sel_d   = min_sel_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d   = ST_ENA;
                    blk_idx_d = 4'd0;
                    mb_cost_d = '0;
                end
            end
            ST_ENA:  state_d = ST_WAIT;
            ST_WAIT: state_d = ST_SCAN;
            ST_SCAN: begin
                min_sad_d = cand_sad;
                min_sel_d = cand_sel;
                if (mode_sel_q == LAST_MODE) begin
                    // Commit on entry to DONE so the block result and the
                    // updated cost are both visible during the DONE cycle.
                    state_d     = ST_DONE;
                    best_sad_d  = cand_sad;
                    best_mode_d = MODE_LUT[cand_sel];
                    mb_cost_d   = mb_cost_q + COST_W'(cand_sad);
                end else begin
                    mode_sel_d = mode_sel_q + 3'd1;
                end
            end
            ST_DONE: begin
                if (blk_idx_q == LAST_BLK) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_ENA;
                    blk_idx_d = blk_idx_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort discards the current block; committed results are untouched.
        if (abort && state_q != ST_IDLE) begin
            state_d     = ST_IDLE;
            mode_sel_d  = 3'd0;
            blk_idx_d   = blk_idx_q;
            best_mode_d = best_mode_q;
            best_sad_d  = best_sad_q;
            mb_cost_d   = mb_cost_q;
            min_sad_d   = min_sad_q;
            min_sel_d   = min_sel_q;
        end

        // Outputs are registered from the next state.
        res_enable_d = (state_d == ST_ENA);
        blk_valid_d  = (state_d == ST_DONE);
        mb_done_d    = (state_d == ST_DONE) && (blk_idx_d == LAST_BLK);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            res_enable_q <= 1'b0;
            mode_sel_q   <= 3'd0;
            blk_idx_q    <= 4'd0;
            blk_valid_q  <= 1'b0;
            mb_done_q    <= 1'b0;
            best_mode_q  <= 4'd0;
            best_sad_q   <= '0;
            mb_cost_q    <= '0;
            min_sad_q    <= '0;
            min_sel_q    <= 3'd0;
        end else begin
            state_q      <= state_d;
            res_enable_q <= res_enable_d;
            mode_sel_q   <= mode_sel_d;
            blk_idx_q    <= blk_idx_d;
            blk_valid_q  <= blk_valid_d;
            mb_done_q    <= mb_done_d;
            best_mode_q  <= best_mode_d;
            best_sad_q   <= best_sad_d;
            mb_cost_q    <= mb_cost_d;
            min_sad_q    <= min_sad_d;
            min_sel_q    <= min_sel_d;
        end
    end

    assign res_enable = res_enable_q;
    assign mode_sel   = mode_sel_q;
    assign blk_idx    = blk_idx_q;
    assign busy       = (state_q != ST_IDLE);
    assign blk_valid  = blk_valid_q;
    assign best_mode  = best_mode_q;
    assign best_sad   = best_sad_q;
    assign mb_cost    = mb_cost_q;
    assign mb_done    = mb_done_q;

endmodule

// File: tb/tb_luma4x4_mode_ctrl.sv
// Scoreboard bench: the expected per-block result and macroblock cost are
// pushed when a run is started and popped when the DUT reports them.
module tb_luma4x4_mode_ctrl;

    localparam int NBLK = 16;

    logic         clk = 1'b0;
    logic         reset, start, abort;
    logic [127:0] res;
    logic         res_enable, busy, blk_valid, mb_done;
    logic [2:0]   mode_sel;
    logic [3:0]   blk_idx, best_mode;
    logic [11:0]  best_sad;
    logic [15:0]  mb_cost;

    logic [127:0] res_tab [8];
    assign res = res_tab[mode_sel];

    luma4x4_mode_ctrl #(.NBLK(NBLK), .NMODE(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .res        (res),
        .res_enable (res_enable),
        .mode_sel   (mode_sel),
        .blk_idx    (blk_idx),
        .busy       (busy),
        .blk_valid  (blk_valid),
        .best_mode  (best_mode),
        .best_sad   (best_sad),
        .mb_cost    (mb_cost),
        .mb_done    (mb_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  idx;
        logic [3:0]  mode;
        logic [11:0] sad;
    } exp_t;

    exp_t        sb_q [$];
    logic [15:0] cost_q [$];
    int          h264 [8] = '{0, 1, 7, 5, 8, 6, 3, 4};
    int          cyc = 0, t0 = 0;
    int          n_run = 0, n_fail = 0;
    int          vld_cnt = 0, done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int byte_abs(input logic [7:0] b);
        return b[7] ? 256 - int'(b) : int'(b);
    endfunction

    function automatic logic [127:0] rep(input logic [7:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = v;
        return r;
    endfunction

    // Reference model: per-mode SAD, strict-less minimum, lowest mode on tie.
    task automatic push_expected(output int bs);
        int s, bm;
        bs = 0;
        bm = 0;
        for (int m = 0; m < 8; m++) begin
            s = 0;
            for (int i = 0; i < 16; i++) s += byte_abs(res_tab[m][8*i +: 8]);
            if (m == 0 || s < bs) begin
                bs = s;
                bm = m;
            end
        end
        for (int b = 0; b < NBLK; b++)
            sb_q.push_back('{idx: 4'(b), mode: 4'(h264[bm]), sad: 12'(bs)});
        cost_q.push_back(16'(NBLK * bs));
    endtask

    task automatic start_run();
        @(negedge clk);
        start = 1'b1;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        int n0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != n0) break;
        end
        chk("mb_done_seen", 32'(done_cnt != n0), 1);
    endtask

    task automatic wait_rel(input int c);
        while (cyc - t0 < c) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_res_enable"}, 32'(res_enable), 0);
        chk({tag, "_mode_sel"},   32'(mode_sel),   0);
        chk({tag, "_blk_idx"},    32'(blk_idx),    0);
        chk({tag, "_busy"},       32'(busy),       0);
        chk({tag, "_blk_valid"},  32'(blk_valid),  0);
        chk({tag, "_best_mode"},  32'(best_mode),  0);
        chk({tag, "_best_sad"},   32'(best_sad),   0);
        chk({tag, "_mb_cost"},    32'(mb_cost),    0);
        chk({tag, "_mb_done"},    32'(mb_done),    0);
    endtask

    // Full run with the current res_tab, then check the results hold.
    task automatic full_run(input string tag);
        int bs;
        push_expected(bs);
        start_run();
        run_to_done(400);
        repeat (5) @(negedge clk);
        chk({tag, "_sb_drained"}, 32'(sb_q.size()), 0);
        chk({tag, "_idle"},       32'(busy), 0);
        chk({tag, "_cost_hold"},  32'(mb_cost), 32'(NBLK * bs));
        chk({tag, "_sad_hold"},   32'(best_sad), 32'(bs));
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset === 1'b1 && blk_valid) begin
            vld_cnt++;
            chk("sb_nonempty", 32'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("blk_idx",   32'(blk_idx),   32'(e.idx));
                chk("best_mode", 32'(best_mode), 32'(e.mode));
                chk("best_sad",  32'(best_sad),  32'(e.sad));
            end
        end
        if (reset === 1'b1 && mb_done) begin
            done_cnt++;
            chk("done_cycle", 32'(cyc - t0), 176);
            chk("cost_nonempty", 32'(cost_q.size() > 0), 1);
            if (cost_q.size() > 0) chk("mb_cost", 32'(mb_cost), 32'(cost_q.pop_front()));
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, d0, bs;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        for (int m = 0; m < 8; m++) res_tab[m] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 0);

        // All-zero residual: V wins with SAD 0
        full_run("zero");

        // All +1 except DDL source (mode_sel 6) all 0
        for (int m = 0; m < 8; m++) res_tab[m] = (m == 6) ? '0 : rep(8'h01);
        full_run("ddl");

        // Saturated -128 everywhere: SAD 2048, cost 32768
        for (int m = 0; m < 8; m++) res_tab[m] = rep(8'h80);
        full_run("max");

        // Tie between mode_sel 2 and 5 at SAD 4, others SAD 10 -> VL (7)
        for (int m = 0; m < 8; m++) begin
            res_tab[m] = '0;
            for (int i = 0; i < 16; i++) begin
                if (m == 2 || m == 5) begin
                    if (i < 4) res_tab[m][8*i +: 8] = 8'h01;
                end else if (i < 10) begin
                    res_tab[m][8*i +: 8] = 8'hFF;
                end
            end
        end
        full_run("tie");

        // Random residuals with a second start at cycle 50 (ignored)
        for (int m = 0; m < 8; m++)
            for (int i = 0; i < 16; i++) res_tab[m][8*i +: 8] = 8'($urandom_range(0, 255));
        v0 = vld_cnt;
        d0 = done_cnt;
        push_expected(bs);
        start_run();
        wait_rel(50);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_to_done(400);
        repeat (30) @(negedge clk);
        chk("restart_vld_count",  32'(vld_cnt - v0), 16);
        chk("restart_done_count", 32'(done_cnt - d0), 1);
        chk("restart_idle",       32'(busy), 0);

        // Abort in SCAN of block 5
        for (int m = 0; m < 8; m++)
            for (int i = 0; i < 16; i++) res_tab[m][8*i +: 8] = 8'($urandom_range(0, 255));
        v0 = vld_cnt;
        d0 = done_cnt;
        push_expected(bs);
        start_run();
        for (int i = 0; i < 200; i++) begin
            if (blk_idx == 4'd5 && mode_sel == 3'd3) break;
            @(negedge clk);
        end
        chk("abort_reached_scan", 32'(blk_idx == 4'd5 && mode_sel == 3'd3), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abort_busy",    32'(busy), 0);
        chk("abort_blk_idx", 32'(blk_idx), 5);
        chk("abort_cost",    32'(mb_cost), 32'(5 * bs));
        repeat (40) @(negedge clk);
        chk("abort_vld_count",  32'(vld_cnt - v0), 5);
        chk("abort_done_count", 32'(done_cnt - d0), 0);
        sb_q.delete();
        cost_q.delete();

        // Reset low at cycle 30: outputs clear immediately, start ignored
        for (int m = 0; m < 8; m++)
            for (int i = 0; i < 16; i++) res_tab[m][8*i +: 8] = 8'($urandom_range(1, 255));
        push_expected(bs);
        start_run();
        wait_rel(30);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("midrst");
        start = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_start_ignored", 32'(busy), 0);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_release_idle", 32'(busy), 0);
        sb_q.delete();
        cost_q.delete();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
